qqspi_bus_arbiter: RTL and testbench

- Two-master front end for the quad/single SPI memory controller: instruction bus (ibus) and data bus (dbus) share one flash + PSRAM controller.
- Decodes each byte address into a chip-select vector and a word address, and selects flash or PSRAM mode.
- Serialises requests with round-robin arbitration and converts the controller's level-held ready into a one-cycle ready pulse per master.
- Sits directly upstream of the SPI controller; the controller's valid/addr/wdata/wstrb/ce_ctrl/PSRAM_SPIFLASH inputs are driven only by this block.

---
 rtl/qqspi_bus_arbiter_if.sv | 51 +++++
 rtl/qqspi_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_qqspi_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qqspi_bus_arbiter_if.sv
// Request/response bundle between the ibus/dbus masters, the arbiter and the SPI controller.
interface qqspi_bus_arbiter_if #(
  parameter int unsigned CHIP_SELECTS = 3
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = 23;
  localparam int unsigned SW = 4;

  logic                    ibus_valid;
  logic [AW-1:0]           ibus_addr;
  logic                    ibus_ready;
  logic [DW-1:0]           ibus_rdata;

  logic                    dbus_valid;
  logic [AW-1:0]           dbus_addr;
  logic [DW-1:0]           dbus_wdata;
  logic [SW-1:0]           dbus_wstrb;
  logic                    dbus_ready;
  logic [DW-1:0]           dbus_rdata;
  logic                    dbus_err;

  logic                    mem_valid;
  logic [MW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic [SW-1:0]           mem_wstrb;
  logic [CHIP_SELECTS-1:0] mem_ce_ctrl;
  logic                    mem_psram;
  logic                    mem_ready;
  logic [DW-1:0]           mem_rdata;

  // Arbiter side: serves the masters, drives the controller.
  modport slave (
    input  ibus_valid, ibus_addr,
    input  dbus_valid, dbus_addr, dbus_wdata, dbus_wstrb,
    input  mem_ready, mem_rdata,
    output ibus_ready, ibus_rdata,
    output dbus_ready, dbus_rdata, dbus_err,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_ce_ctrl, mem_psram
  );

  // Environment side: the two masters plus the controller.
  modport master (
    output ibus_valid, ibus_addr,
    output dbus_valid, dbus_addr, dbus_wdata, dbus_wstrb,
    output mem_ready, mem_rdata,
    input  ibus_ready, ibus_rdata,
    input  dbus_ready, dbus_rdata, dbus_err,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_ce_ctrl, mem_psram
  );
endinterface

// File: rtl/qqspi_bus_arbiter.sv
// Round-robin ibus/dbus arbiter with flash/PSRAM address decode in front of the SPI memory controller.
module qqspi_bus_arbiter #(
  parameter int unsigned CHIP_SELECTS = 3,
  parameter logic [31:0] FLASH_BASE   = 32'h2000_0000,
  parameter logic [31:0] PSRAM_BASE   = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  qqspi_bus_arbiter_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = 23;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

  state_t                  r_state,      w_state;
  logic                    r_last_d,     w_last_d;
  logic                    r_gnt_d,      w_gnt_d;
  logic                    r_err,        w_err;
  logic                    r_did_mem,    w_did_mem;
  logic [DW-1:0]           r_rdata_cap,  w_rdata_cap;

  logic                    r_mem_valid,  w_mem_valid;
  logic [MW-1:0]           r_mem_addr,   w_mem_addr;
  logic [DW-1:0]           r_mem_wdata,  w_mem_wdata;
  logic [SW-1:0]           r_mem_wstrb,  w_mem_wstrb;
  logic [CHIP_SELECTS-1:0] r_mem_ce,     w_mem_ce;
  logic                    r_mem_psram,  w_mem_psram;

  logic                    r_ibus_ready, w_ibus_ready;
  logic [DW-1:0]           r_ibus_rdata, w_ibus_rdata;
  logic                    r_dbus_ready, w_dbus_ready;
  logic [DW-1:0]           r_dbus_rdata, w_dbus_rdata;
  logic                    r_dbus_err,   w_dbus_err;

  logic                    w_pick_d;
  logic [AW-1:0]           w_req_addr;
  logic [DW-1:0]           w_req_wdata;
  logic [SW-1:0]           w_req_wstrb;
  logic                    w_is_flash;
  logic                    w_is_psram;
  logic                    w_dec_ok;
  logic [MW-1:0]           w_dec_addr;
  logic [CHIP_SELECTS-1:0] w_dec_ce;
  logic [1:0]              w_unused_lsb;

  // Pick a master (the one not granted last on a tie) and decode its address.
  always_comb begin
    w_pick_d    = bus.dbus_valid && (!bus.ibus_valid || !r_last_d);
    w_req_addr  = w_pick_d ? bus.dbus_addr  : bus.ibus_addr;
    w_req_wdata = w_pick_d ? bus.dbus_wdata : DW'(0);
    w_req_wstrb = w_pick_d ? bus.dbus_wstrb : SW'(0);
    w_is_flash  = (w_req_addr[31:24] == FLASH_BASE[31:24]);
    w_is_psram  = (w_req_addr[31:24] == PSRAM_BASE[31:24]);
    // Flash is read-only through this path; a write there is answered with an error.
    w_dec_ok    = w_is_psram || (w_is_flash && (w_req_wstrb == SW'(0)));
    if (w_is_flash) begin
      w_dec_ce   = CHIP_SELECTS'(3'b001);
      w_dec_addr = {1'b0, w_req_addr[23:2]};
    end else begin
      w_dec_ce   = w_req_addr[23] ? CHIP_SELECTS'(3'b100) : CHIP_SELECTS'(3'b010);
      w_dec_addr = {2'b00, w_req_addr[22:2]};
    end
    w_unused_lsb = w_req_addr[1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state      = r_state;
    w_last_d     = r_last_d;
    w_gnt_d      = r_gnt_d;
    w_err        = r_err;
    w_did_mem    = r_did_mem;
    w_rdata_cap  = r_rdata_cap;
    w_mem_valid  = r_mem_valid;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_mem_wstrb  = r_mem_wstrb;
    w_mem_ce     = r_mem_ce;
    w_mem_psram  = r_mem_psram;
    w_ibus_ready = 1'b0;
    w_ibus_rdata = r_ibus_rdata;
    w_dbus_ready = 1'b0;
    w_dbus_rdata = r_dbus_rdata;
    w_dbus_err   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.ibus_valid || bus.dbus_valid) begin
          w_gnt_d     = w_pick_d;
          w_err       = !w_dec_ok;
          w_did_mem   = w_dec_ok;
          w_rdata_cap = DW'(0);
          if (w_dec_ok) begin
            w_mem_valid = 1'b1;
            w_mem_addr  = w_dec_addr;
            w_mem_wdata = w_req_wdata;
            w_mem_wstrb = w_req_wstrb;
            w_mem_ce    = w_dec_ce;
            w_mem_psram = w_is_psram;
            w_state     = ISSUE;
          end else begin
            w_state     = RESP;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          w_rdata_cap = bus.mem_rdata;
          w_mem_valid = 1'b0;
          w_mem_addr  = MW'(0);
          w_mem_wdata = DW'(0);
          w_mem_wstrb = SW'(0);
          w_mem_ce    = CHIP_SELECTS'(0);
          w_mem_psram = 1'b0;
          w_state     = RESP;
        end
      end
      RESP: begin
        if (r_gnt_d) begin
          w_dbus_ready = 1'b1;
          w_dbus_rdata = r_err ? DW'(0) : r_rdata_cap;
          w_dbus_err   = r_err;
        end else begin
          w_ibus_ready = 1'b1;
          w_ibus_rdata = r_err ? DW'(0) : r_rdata_cap;
        end
        w_last_d = r_gnt_d;
        w_state  = r_did_mem ? DRAIN : IDLE;
      end
      DRAIN: begin
        // The controller's ready must fall before another request may start.
        if (!bus.mem_ready) begin
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // State and output registers; reset starts with dbus as last grant so ibus wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b1;
      r_gnt_d      <= 1'b0;
      r_err        <= 1'b0;
      r_did_mem    <= 1'b0;
      r_rdata_cap  <= DW'(0);
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= MW'(0);
      r_mem_wdata  <= DW'(0);
      r_mem_wstrb  <= SW'(0);
      r_mem_ce     <= CHIP_SELECTS'(0);
      r_mem_psram  <= 1'b0;
      r_ibus_ready <= 1'b0;
      r_ibus_rdata <= DW'(0);
      r_dbus_ready <= 1'b0;
      r_dbus_rdata <= DW'(0);
      r_dbus_err   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_d     <= w_last_d;
      r_gnt_d      <= w_gnt_d;
      r_err        <= w_err;
      r_did_mem    <= w_did_mem;
      r_rdata_cap  <= w_rdata_cap;
      r_mem_valid  <= w_mem_valid;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_wstrb  <= w_mem_wstrb;
      r_mem_ce     <= w_mem_ce;
      r_mem_psram  <= w_mem_psram;
      r_ibus_ready <= w_ibus_ready;
      r_ibus_rdata <= w_ibus_rdata;
      r_dbus_ready <= w_dbus_ready;
      r_dbus_rdata <= w_dbus_rdata;
      r_dbus_err   <= w_dbus_err;
    end
  end

  assign bus.mem_valid   = r_mem_valid;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_wstrb   = r_mem_wstrb;
  assign bus.mem_ce_ctrl = r_mem_ce;
  assign bus.mem_psram   = r_mem_psram;
  assign bus.ibus_ready  = r_ibus_ready;
  assign bus.ibus_rdata  = r_ibus_rdata;
  assign bus.dbus_ready  = r_dbus_ready;
  assign bus.dbus_rdata  = r_dbus_rdata;
  assign bus.dbus_err    = r_dbus_err;

endmodule

// File: tb/tb_qqspi_bus_arbiter.sv
// Directed bench for qqspi_bus_arbiter with a small SPI controller model.
module tb_qqspi_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qqspi_bus_arbiter_if #(.CHIP_SELECTS(3)) bus ();

  qqspi_bus_arbiter #(
    .CHIP_SELECTS(3),
    .FLASH_BASE  (32'h2000_0000),
    .PSRAM_BASE  (32'h8000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Controller model: ready 3 edges after valid is seen, held while valid, plus extra hold cycles.
  logic [31:0] ctl_data  = 32'h0;
  int          ctl_extra = 0;
  int          ctl_cnt   = 0;
  int          ctl_hold  = 0;

  always @(posedge clk) begin
    if (reset) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 32'h0;
      ctl_cnt       <= 0;
      ctl_hold      <= 0;
    end else if (bus.mem_ready) begin
      if (!bus.mem_valid) begin
        if (ctl_hold == 0) bus.mem_ready <= 1'b0;
        else               ctl_hold <= ctl_hold - 1;
      end
    end else if (bus.mem_valid) begin
      if (ctl_cnt == 2) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= ctl_data;
        ctl_cnt       <= 0;
        ctl_hold      <= ctl_extra;
      end else begin
        ctl_cnt <= ctl_cnt + 1;
      end
    end
  end

  // Protocol monitor on the falling edge.
  int   mv_rises = 0, rise_viol = 0, ce_viol = 0, pulse_viol = 0, i_pulses = 0, d_pulses = 0;
  logic prev_mv = 1'b0, prev_ir = 1'b0, prev_dr = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_mv <= 1'b0;
      prev_ir <= 1'b0;
      prev_dr <= 1'b0;
    end else begin
      if (bus.mem_valid && !prev_mv) begin
        mv_rises <= mv_rises + 1;
        if (bus.mem_ready) rise_viol <= rise_viol + 1;
      end
      if (!bus.mem_valid && bus.mem_ce_ctrl != 3'b000) ce_viol <= ce_viol + 1;
      if ((bus.ibus_ready && prev_ir) || (bus.dbus_ready && prev_dr)) pulse_viol <= pulse_viol + 1;
      if (bus.ibus_ready) i_pulses <= i_pulses + 1;
      if (bus.dbus_ready) d_pulses <= d_pulses + 1;
      prev_mv <= bus.mem_valid;
      prev_ir <= bus.ibus_ready;
      prev_dr <= bus.dbus_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First mem transfer seen during the last wait, and the response seen.
  logic        cap_seen;
  logic [22:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_ce;
  logic        cap_ps;
  logic [31:0] got_rdata;
  logic        got_err;

  // Wait for either ready pulse; cyc counts edges since the call, mr_cyc the edge mem_ready was first seen.
  task automatic wait_any(input string tag, input int budget, output bit who_d, output int cyc,
                          output int mr_cyc);
    bit done = 1'b0;
    cyc = 0; mr_cyc = -1; who_d = 1'b0; cap_seen = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_valid && !cap_seen) begin
        cap_seen  = 1'b1;
        cap_addr  = bus.mem_addr;
        cap_wdata = bus.mem_wdata;
        cap_wstrb = bus.mem_wstrb;
        cap_ce    = bus.mem_ce_ctrl;
        cap_ps    = bus.mem_psram;
      end
      if (bus.mem_ready && mr_cyc < 0) mr_cyc = cyc;
      if (bus.ibus_ready || bus.dbus_ready) begin
        who_d     = bus.dbus_ready;
        got_rdata = bus.dbus_ready ? bus.dbus_rdata : bus.ibus_rdata;
        got_err   = bus.dbus_err;
        done      = 1'b1;
      end else if (cyc >= budget) begin
        chk({tag, "_timeout"}, 32'(cyc), 32'(0));
        done = 1'b1;
      end
    end
  endtask

  task automatic idle_masters();
    bus.ibus_valid = 1'b0;
    bus.ibus_addr  = 32'h0;
    bus.dbus_valid = 1'b0;
    bus.dbus_addr  = 32'h0;
    bus.dbus_wdata = 32'h0;
    bus.dbus_wstrb = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  bit who;
  int cyc, mr, rises0, ip0;

  initial begin
    idle_masters();
    step(3);

    // Reset state
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_mem_ce", 32'(bus.mem_ce_ctrl), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_psram", 32'(bus.mem_psram), 32'h0);
    chk("rst_ready", 32'({bus.ibus_ready, bus.dbus_ready, bus.dbus_err}), 32'h0);
    reset = 1'b0;
    step(1);

    // ibus flash read
    ctl_data = 32'hDEAD_BEEF;
    bus.ibus_valid = 1'b1; bus.ibus_addr = 32'h2000_0010;
    wait_any("t1", 30, who, cyc, mr);
    idle_masters();
    chk("t1_who", 32'(who), 32'h0);
    chk("t1_ce", 32'(cap_ce), 32'h1);
    chk("t1_psram", 32'(cap_ps), 32'h0);
    chk("t1_addr", 32'(cap_addr), 32'h4);
    chk("t1_rdata", got_rdata, 32'hDEAD_BEEF);
    chk("t1_lat_after_memready", 32'(cyc - mr), 32'h2);
    chk("t1_memvalid_dropped", 32'(bus.mem_valid), 32'h0);
    step(1);
    chk("t1_pulse_one_cycle", 32'(bus.ibus_ready), 32'h0);
    step(3);

    // dbus PSRAM bank1 write
    bus.dbus_valid = 1'b1; bus.dbus_addr = 32'h8080_0008;
    bus.dbus_wdata = 32'h0000_1234; bus.dbus_wstrb = 4'b0011;
    wait_any("t2", 30, who, cyc, mr);
    idle_masters();
    chk("t2_who", 32'(who), 32'h1);
    chk("t2_ce", 32'(cap_ce), 32'h4);
    chk("t2_psram", 32'(cap_ps), 32'h1);
    chk("t2_addr", 32'(cap_addr), 32'h2);
    chk("t2_wstrb", 32'(cap_wstrb), 32'h3);
    chk("t2_wdata", cap_wdata, 32'h0000_1234);
    chk("t2_err", 32'(got_err), 32'h0);
    step(3);

    // Simultaneous requests after reset, held continuously: i, d, i, d
    do_reset();
    ctl_data = 32'h5555_AAAA;
    bus.ibus_valid = 1'b1; bus.ibus_addr = 32'h2000_0100;
    bus.dbus_valid = 1'b1; bus.dbus_addr = 32'h8000_0040;
    for (int k = 0; k < 4; k++) begin
      wait_any("t3", 40, who, cyc, mr);
      chk($sformatf("t3_grant%0d", k), 32'(who), 32'(k % 2));
      if (k == 0) chk("t3_i_addr", 32'(cap_addr), 32'h40);
      if (k == 1) begin
        chk("t3_d_ce", 32'(cap_ce), 32'h2);
        chk("t3_d_addr", 32'(cap_addr), 32'h10);
        chk("t3_d_rdata", got_rdata, 32'h5555_AAAA);
      end
    end
    idle_masters();
    step(4);

    // dbus decode miss: no mem activity, error response
    rises0 = mv_rises;
    bus.dbus_valid = 1'b1; bus.dbus_addr = 32'h1000_0000;
    wait_any("t4", 20, who, cyc, mr);
    idle_masters();
    chk("t4_lat", 32'(cyc), 32'h2);
    chk("t4_who", 32'(who), 32'h1);
    chk("t4_rdata", got_rdata, 32'h0);
    chk("t4_err", 32'(got_err), 32'h1);
    step(2);
    chk("t4_no_mem", 32'(mv_rises - rises0), 32'h0);

    // dbus write to flash: error, no mem activity
    rises0 = mv_rises;
    bus.dbus_valid = 1'b1; bus.dbus_addr = 32'h2000_0000;
    bus.dbus_wdata = 32'hFFFF_FFFF; bus.dbus_wstrb = 4'b1111;
    wait_any("t5", 20, who, cyc, mr);
    idle_masters();
    chk("t5_lat", 32'(cyc), 32'h2);
    chk("t5_err", 32'(got_err), 32'h1);
    step(2);
    chk("t5_no_mem", 32'(mv_rises - rises0), 32'h0);

    // ibus decode miss returns zero
    bus.ibus_valid = 1'b1; bus.ibus_addr = 32'h0000_0000;
    wait_any("t5i", 20, who, cyc, mr);
    idle_masters();
    chk("t5i_who", 32'(who), 32'h0);
    chk("t5i_rdata", got_rdata, 32'h0);
    chk("t5i_lat", 32'(cyc), 32'h2);
    step(3);

    // Long mem_ready tail; immediate ibus re-request must wait for it to fall
    ctl_extra = 3; ctl_data = 32'h0BAD_F00D;
    bus.ibus_valid = 1'b1; bus.ibus_addr = 32'h8000_0004;
    wait_any("t6a", 30, who, cyc, mr);
    chk("t6a_ce", 32'(cap_ce), 32'h2);
    chk("t6a_addr", 32'(cap_addr), 32'h1);
    chk("t6a_rdata", got_rdata, 32'h0BAD_F00D);
    ctl_data = 32'hCAFE_0001;
    bus.ibus_addr = 32'h2000_0008;
    wait_any("t6b", 40, who, cyc, mr);
    idle_masters();
    chk("t6b_ce", 32'(cap_ce), 32'h1);
    chk("t6b_addr", 32'(cap_addr), 32'h2);
    chk("t6b_rdata", got_rdata, 32'hCAFE_0001);
    chk("t6_mv_during_ready", 32'(rise_viol), 32'h0);
    ctl_extra = 0;
    step(8);

    // Reset asserted during ISSUE
    ip0 = i_pulses;
    bus.ibus_valid = 1'b1; bus.ibus_addr = 32'h2000_0010;
    cyc = 0;
    while (!bus.mem_valid && cyc < 10) begin
      step(1);
      cyc++;
    end
    chk("t7_reached_issue", 32'(bus.mem_valid), 32'h1);
    reset = 1'b1;
    step(1);
    chk("t7_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("t7_mem_ce", 32'(bus.mem_ce_ctrl), 32'h0);
    chk("t7_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("t7_ready", 32'({bus.ibus_ready, bus.dbus_ready}), 32'h0);
    idle_masters();
    step(1);
    reset = 1'b0;
    step(10);
    chk("t7_no_pulse", 32'(i_pulses - ip0), 32'h0);

    // Global protocol invariants
    chk("ce_zero_when_idle", 32'(ce_viol), 32'h0);
    chk("ready_single_cycle", 32'(pulse_viol), 32'h0);
    chk("no_mv_while_ready", 32'(rise_viol), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
